amo_responder: RTL and testbench

AMO_RESPONDER -- requirements
Module: amo_responder

---
 rtl/amo_pkg.sv | 28 ++
 rtl/amo_alu.sv | 38 +++
 rtl/amo_responder.sv | 197 +++++++++++++++++++
 tb/tb_amo_responder.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amo_pkg.sv
// Shared types for the AMO responder: op encoding and the AMO request bundle.
package amo_pkg;

    localparam int unsigned AMO_ADDR_W = 32;
    localparam int unsigned AMO_DATA_W = 32;

    typedef enum logic [3:0] {
        AmoSwap = 4'd0,
        AmoAdd  = 4'd1,
        AmoAnd  = 4'd2,
        AmoOr   = 4'd3,
        AmoXor  = 4'd4,
        AmoMin  = 4'd5,
        AmoMax  = 4'd6,
        AmoMinu = 4'd7,
        AmoMaxu = 4'd8,
        AmoLr   = 4'd9,
        AmoSc   = 4'd10
    } amo_op_e;

    typedef struct packed {
        logic                  valid;
        amo_op_e               op;
        logic [AMO_ADDR_W-1:0] addr;
        logic [AMO_DATA_W-1:0] data;
    } amo_mem_s;

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO datapath: computes the value written back from the old word,
// the request operand and the op.
module amo_alu
    import amo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic [DATA_WIDTH-1:0] i_operand,
    input  amo_op_e               i_op,
    output logic [DATA_WIDTH-1:0] o_new
);

    logic w_lt_s;
    logic w_lt_u;

    assign w_lt_s = $signed(i_old) < $signed(i_operand);
    assign w_lt_u = i_old < i_operand;

    always_comb begin
        o_new = i_old;
        unique case (i_op)
            AmoSwap: o_new = i_operand;
            AmoAdd:  o_new = i_old + i_operand;
            AmoAnd:  o_new = i_old & i_operand;
            AmoOr:   o_new = i_old | i_operand;
            AmoXor:  o_new = i_old ^ i_operand;
            AmoMin:  o_new = w_lt_s ? i_old : i_operand;
            AmoMax:  o_new = w_lt_s ? i_operand : i_old;
            AmoMinu: o_new = w_lt_u ? i_old : i_operand;
            AmoMaxu: o_new = w_lt_u ? i_operand : i_old;
            // LR leaves the word alone; SC stores its operand when allowed to write.
            AmoSc:   o_new = i_operand;
            default: o_new = i_old;
        endcase
    end

endmodule

// File: rtl/amo_responder.sv
// Word RAM serving plain loads/stores and atomic read-modify-write requests.
// Define AMO_LRSC_EN to add the LR/SC reservation.
module amo_responder
    import amo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [3:0]            mask,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  amo_mem_s              amo_to_mem_if,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_resp,
    output logic                  busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRdResp,
        StAmoRd,
        StAmoWr
    } state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]      r_idx;
    amo_op_e               r_op;
    logic [DATA_WIDTH-1:0] r_operand;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;
    logic                  r_read_resp;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic [IDX_W-1:0]      w_addr_idx;
    logic [IDX_W-1:0]      w_amo_idx;
    logic                  w_accept_amo;
    logic                  w_accept_st;
    logic                  w_accept_ld;
    logic [DATA_WIDTH-1:0] w_bmask;
    logic [DATA_WIDTH-1:0] w_store_word;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_new;
    logic                  w_amo_we;
    logic [DATA_WIDTH-1:0] w_resp_data;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_unused;

    // Dropping the upper address bits is what makes out-of-range indices wrap.
    assign w_addr_idx = addr[IDX_W+1:2];
    assign w_amo_idx  = amo_to_mem_if.addr[IDX_W+1:2];
    assign w_unused   = ^{addr[ADDR_WIDTH-1:IDX_W+2], addr[1:0],
                          amo_to_mem_if.addr[AMO_ADDR_W-1:IDX_W+2], amo_to_mem_if.addr[1:0]};

    assign w_accept_amo = (r_state == StIdle) && amo_to_mem_if.valid;
    assign w_accept_st  = (r_state == StIdle) && !amo_to_mem_if.valid && write_en;
    assign w_accept_ld  = (r_state == StIdle) && !amo_to_mem_if.valid && !write_en && read_en;

    always_comb begin
        w_bmask = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            w_bmask[b] = mask[2'(b / 8)];
        end
    end

    assign w_store_word = (r_mem[w_addr_idx] & ~w_bmask) | (data_in & w_bmask);
    assign w_old        = r_mem[r_idx];

    amo_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_old     (w_old),
        .i_operand (r_operand),
        .i_op      (r_op),
        .o_new     (w_new)
    );

`ifdef AMO_LRSC_EN
    logic             r_resv_valid;
    logic [IDX_W-1:0] r_resv_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resv_valid <= 1'b0;
            r_resv_idx   <= '0;
        end else if (r_state == StAmoRd && r_op == AmoLr) begin
            r_resv_valid <= 1'b1;
            r_resv_idx   <= r_idx;
        end else if (r_state == StAmoRd && r_op == AmoSc) begin
            r_resv_valid <= 1'b0;
        end else if (w_mem_we && w_mem_idx == r_resv_idx) begin
            r_resv_valid <= 1'b0;
        end
    end
`endif

    // Decides in AMO_RD whether AMO_WR may write and what the response carries.
    always_comb begin
        w_amo_we    = 1'b1;
        w_resp_data = w_old;
        if (r_op == AmoLr) begin
            w_amo_we = 1'b0;
        end else if (r_op == AmoSc) begin
`ifdef AMO_LRSC_EN
            w_amo_we = r_resv_valid && (r_resv_idx == r_idx);
`else
            w_amo_we = 1'b0;
`endif
            w_resp_data = w_amo_we ? '0 : DATA_WIDTH'(1);
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept_amo) begin
                    w_state_d = StAmoRd;
                end else if (w_accept_ld) begin
                    w_state_d = StRdResp;
                end
            end
            StRdResp: w_state_d = StIdle;
            StAmoRd:  w_state_d = StAmoWr;
            StAmoWr:  w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_op        <= AmoSwap;
            r_operand   <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_read_resp <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_read_resp <= 1'b0;
            if (w_accept_amo) begin
                r_idx     <= w_amo_idx;
                r_op      <= amo_to_mem_if.op;
                r_operand <= DATA_WIDTH'(amo_to_mem_if.data);
            end else if (w_accept_ld) begin
                r_read_resp <= 1'b1;
                r_data_out  <= r_mem[w_addr_idx];
            end
            if (r_state == StAmoRd) begin
                r_read_resp <= 1'b1;
                r_data_out  <= w_resp_data;
                r_wdata     <= w_new;
                r_we        <= w_amo_we;
            end else if (r_state == StAmoWr) begin
                r_we <= 1'b0;
            end
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = w_addr_idx;
        w_mem_wdata = w_store_word;
        if (w_accept_st) begin
            w_mem_we = 1'b1;
        end else if (r_state == StAmoWr && r_we) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = r_idx;
            w_mem_wdata = r_wdata;
        end
    end

    // RAM is never cleared; reset only suppresses an in-flight write.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // A reset landing in AMO_WR also hides that cycle's response pulse.
    assign read_resp = r_read_resp & ~rst;
    assign data_out  = r_data_out;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_amo_responder.sv
// Scoreboard bench for amo_responder: expected responses are queued as requests are driven.
`timescale 1ns/1ps
module tb_amo_responder;
    import amo_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          read_en;
    logic          write_en;
    logic [3:0]    mask;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    amo_mem_s      amo;
    logic [DW-1:0] data_out;
    logic          read_resp;
    logic          busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    amo_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .read_en       (read_en),
        .write_en      (write_en),
        .mask          (mask),
        .addr          (addr),
        .data_in       (data_in),
        .amo_to_mem_if (amo),
        .data_out      (data_out),
        .read_resp     (read_resp),
        .busy          (busy)
    );

    function automatic logic [31:0] model(input amo_op_e op, input logic [31:0] o, input logic [31:0] b);
        case (op)
            AmoSwap: return b;
            AmoAdd:  return o + b;
            AmoAnd:  return o & b;
            AmoOr:   return o | b;
            AmoXor:  return o ^ b;
            AmoMin:  return ($signed(o) < $signed(b)) ? o : b;
            AmoMax:  return ($signed(o) > $signed(b)) ? o : b;
            AmoMinu: return (o < b) ? o : b;
            AmoMaxu: return (o > b) ? o : b;
            default: return o;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        read_en   = 1'b0;
        write_en  = 1'b0;
        amo.valid = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        write_en = 1'b1;
        addr     = a;
        mask     = m;
        data_in  = d;
        tick();
        write_en = 1'b0;
    endtask

    task automatic drive_load(input logic [31:0] a);
        read_en = 1'b1;
        addr    = a;
    endtask

    task automatic drive_amo(input amo_op_e op, input logic [31:0] a, input logic [31:0] d);
        amo.valid = 1'b1;
        amo.op    = op;
        amo.addr  = a;
        amo.data  = d;
    endtask

    // Waits (bounded) for a response pulse, then steps one more cycle back to IDLE.
    task automatic wait_resp(output logic got, output int lat, output logic [31:0] d);
        got = 1'b0;
        lat = 0;
        d   = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            clear_req();
            lat++;
            if (read_resp === 1'b1) begin
                got = 1'b1;
                d   = data_out;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_req();
        mask    = 4'h0;
        addr    = '0;
        data_in = '0;
        amo     = '0;
        repeat (3) tick();
        n_checks++;
        if (read_resp !== 1'b0 || busy !== 1'b0 || data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: resp=%b busy=%b data=%h, required 0 0 00000000",
                     read_resp, busy, data_out);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (read_resp !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: resp=%b busy=%b, required 0 0", read_resp, busy);
        end
    endtask

    task automatic test_load();
        logic got; int lat; logic [31:0] d, e;
        do_store(32'h10, 4'hF, 32'h11223344);
        n_checks++;
        if (busy !== 1'b0 || read_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL store_no_resp: busy=%b resp=%b, required 0 0", busy, read_resp);
        end
        exp_q.push_back(32'h11223344);
        drive_load(32'h10);
        wait_resp(got, lat, d);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e || lat != 1) begin
            n_fail++;
            $display("FAIL load: got=%b lat=%0d data=%h, required 1 1 %h", got, lat, d, e);
        end
        tick();
        n_checks++;
        if (read_resp !== 1'b0 || data_out !== e) begin
            n_fail++;
            $display("FAIL data_hold: resp=%b data=%h, required 0 %h", read_resp, data_out, e);
        end
    endtask

    task automatic test_masked_store();
        logic got; int lat; logic [31:0] d, e;
        do_store(32'h10, 4'b0101, 32'hAABBCCDD);
        exp_q.push_back(32'h11BB33DD);
        drive_load(32'h10);
        wait_resp(got, lat, d);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) begin
            n_fail++;
            $display("FAIL masked_store: got=%b data=%h, required 1 %h", got, d, e);
        end
    endtask

    task automatic test_amo_add();
        logic got; int lat; logic [31:0] d, e;
        do_store(32'h40, 4'hF, 32'hFFFFFFFF);
        exp_q.push_back(32'hFFFFFFFF);
        drive_amo(AmoAdd, 32'h40, 32'h1);
        tick();
        clear_req();
        n_checks++;
        if (busy !== 1'b1 || read_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL add_cycle1: busy=%b resp=%b, required 1 0", busy, read_resp);
        end
        drive_load(32'h10);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (busy !== 1'b1 || read_resp !== 1'b1 || data_out !== e) begin
            n_fail++;
            $display("FAIL add_cycle2: busy=%b resp=%b data=%h, required 1 1 %h",
                     busy, read_resp, data_out, e);
        end
        tick();
        read_en = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || read_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL add_idle: busy=%b resp=%b, required 0 0", busy, read_resp);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || read_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore: busy=%b resp=%b, required 0 0", busy, read_resp);
        end
        exp_q.push_back(32'h00000000);
        drive_load(32'h40);
        wait_resp(got, lat, d);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) begin
            n_fail++;
            $display("FAIL add_ram: got=%b data=%h, required 1 %h", got, d, e);
        end
    endtask

    task automatic test_ops();
        amo_op_e     ops [11];
        logic [31:0] olds[11];
        logic [31:0] args[11];
        logic got; int lat; logic [31:0] d, e;
        ops  = '{AmoMin, AmoMinu, AmoMax, AmoMaxu, AmoSwap, AmoAdd, AmoAnd, AmoOr, AmoXor,
                 AmoMin, AmoMaxu};
        olds = '{32'h1, 32'h1, 32'h1, 32'h1, 0, 0, 0, 0, 0, 0, 0};
        args = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 4; i < 11; i++) begin
            olds[i] = $urandom;
            args[i] = $urandom;
        end
        for (int i = 0; i < 11; i++) begin
            do_store(32'h80, 4'hF, olds[i]);
            exp_q.push_back(olds[i]);
            exp_q.push_back(model(ops[i], olds[i], args[i]));
            drive_amo(ops[i], 32'h80, args[i]);
            wait_resp(got, lat, d);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || d !== e || lat != 2) begin
                n_fail++;
                $display("FAIL amo_%s_old: got=%b lat=%0d data=%h, required 1 2 %h",
                         ops[i].name(), got, lat, d, e);
            end
            drive_load(32'h80);
            wait_resp(got, lat, d);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || d !== e) begin
                n_fail++;
                $display("FAIL amo_%s_new: got=%b data=%h, required 1 %h",
                         ops[i].name(), got, d, e);
            end
        end
    endtask

    task automatic test_priority();
        logic got; int lat; logic [31:0] d, e;
        do_store(32'h100, 4'hF, 32'h0BADF00D);
        exp_q.push_back(32'h0BADF00D);
        exp_q.push_back(32'h12345678);
        drive_amo(AmoSwap, 32'h100, 32'h12345678);
        write_en = 1'b1;
        addr     = 32'h100;
        mask     = 4'hF;
        data_in  = 32'h99999999;
        read_en  = 1'b1;
        wait_resp(got, lat, d);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) begin
            n_fail++;
            $display("FAIL prio_amo: got=%b data=%h, required 1 %h", got, d, e);
        end
        drive_load(32'h100);
        wait_resp(got, lat, d);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) begin
            n_fail++;
            $display("FAIL prio_store_dropped: got=%b data=%h, required 1 %h", got, d, e);
        end
        // Store beats load: no response should appear.
        write_en = 1'b1;
        read_en  = 1'b1;
        addr     = 32'h104;
        mask     = 4'hF;
        data_in  = 32'h77665544;
        tick();
        clear_req();
        tick();
        n_checks++;
        if (read_resp !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_store_load: resp=%b busy=%b, required 0 0", read_resp, busy);
        end
        exp_q.push_back(32'h77665544);
        drive_load(32'h104);
        wait_resp(got, lat, d);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) begin
            n_fail++;
            $display("FAIL prio_store_data: got=%b data=%h, required 1 %h", got, d, e);
        end
    endtask

    task automatic test_wrap();
        logic got; int lat; logic [31:0] d, e;
        do_store(DEPTH * 4 + 32'h14, 4'hF, 32'h5A5A1234);
        exp_q.push_back(32'h5A5A1234);
        drive_load(32'h14);
        wait_resp(got, lat, d);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) begin
            n_fail++;
            $display("FAIL addr_wrap: got=%b data=%h, required 1 %h", got, d, e);
        end
    endtask

    task automatic test_lrsc();
        logic got; int lat; logic [31:0] d, e;
        logic [31:0] exp_list[$];
        do_store(32'h20, 4'hF, 32'hCAFE0000);
`ifdef AMO_LRSC_EN
        exp_list = '{32'hCAFE0000, 32'h0, 32'h5, 32'h5, 32'h1, 32'h9};
`else
        exp_list = '{32'hCAFE0000, 32'h1, 32'hCAFE0000, 32'hCAFE0000, 32'h1, 32'h9};
`endif
        foreach (exp_list[i]) exp_q.push_back(exp_list[i]);
        for (int step = 0; step < 6; step++) begin
            case (step)
                0, 3:    drive_amo(AmoLr, 32'h20, 32'h0);
                1:       drive_amo(AmoSc, 32'h20, 32'h5);
                4: begin
                    do_store(32'h20, 4'hF, 32'h9);
                    drive_amo(AmoSc, 32'h20, 32'h7);
                end
                default: drive_load(32'h20);
            endcase
            wait_resp(got, lat, d);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || d !== e) begin
                n_fail++;
                $display("FAIL lrsc_step%0d: got=%b data=%h, required 1 %h", step, got, d, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic got; int lat; logic [31:0] d, e;
        do_store(32'h30, 4'hF, 32'h00001234);
        drive_amo(AmoSwap, 32'h30, 32'h0000DEAD);
        tick();
        clear_req();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_amo_rd: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || read_resp !== 1'b0 || data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b resp=%b data=%h, required 0 0 00000000",
                     busy, read_resp, data_out);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (read_resp !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_late_resp: resp=%b busy=%b, required 0 0", read_resp, busy);
        end
        exp_q.push_back(32'h00001234);
        drive_load(32'h30);
        wait_resp(got, lat, d);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) begin
            n_fail++;
            $display("FAIL abort_ram: got=%b data=%h, required 1 %h", got, d, e);
        end
    endtask

    task automatic test_back_to_back();
        logic got; int lat; logic [31:0] d, e;
        logic [31:0] words[4];
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom;
            do_store(32'h200 + i * 4, 4'hF, words[i]);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(words[3 - i]);
            drive_load(32'h200 + (3 - i) * 4);
            wait_resp(got, lat, d);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || d !== e) begin
                n_fail++;
                $display("FAIL b2b_load%0d: got=%b data=%h, required 1 %h", i, got, d, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(words[0] + i);
            drive_amo(AmoAdd, 32'h200, 32'h1);
            wait_resp(got, lat, d);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || d !== e) begin
                n_fail++;
                $display("FAIL b2b_add%0d: got=%b data=%h, required 1 %h", i, got, d, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_masked_store();
        test_amo_add();
        test_ops();
        test_priority();
        test_wrap();
        test_lrsc();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
